md5_iter_ctrl: RTL and testbench
================================

MD5_ITER_CTRL -- requirements
Module: md5_iter_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port blk_valid, input, 1, a padded 512-bit block is offered.
REQ-004 SHALL have port blk_ready, output, 1, the block can be accepted this cycle.
REQ-005 SHALL have port blk_data, input, 512, the block; word M[g] = blk_data[32g+31:32g], g = 0..15.
REQ-006 SHALL have port blk_first, input, 1, qualified by blk_valid; reloads the chaining value with the IV before this block.
REQ-007 SHALL have port dig_valid, output, 1, digest is valid.
REQ-008 SHALL have port dig_ready, input, 1, the consumer accepts the digest.
REQ-009 SHALL have port digest, output, 128, chaining value packed {D,C,B,A}, with A in [31:0].
REQ-010 SHALL have port busy, output, 1, high in RUN and DONE.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE: blk_ready=1; blk_valid&blk_ready loads working A..D from the chaining value (IV if blk_first), latches the block, sets step counter cnt=0, and goes to RUN.
REQ-013 In RUN: one MD5 step per cycle, cnt 0..63.
- round r = cnt[5:4]; F = (B&C)|(~B&D), (B&D)|(C&~D), B^C^D, C^(B|~D).
- g = cnt, (5cnt+1) mod 16, (3cnt+5) mod 16, (7cnt) mod 16.
- Update: A'=D, D'=C, C'=B, B' = B + rotl(A+F+K[cnt]+M[g], S[cnt]).
- All adds mod 2^32.
REQ-014 On the step-63 edge: chaining value += new working A..D (per 32-bit word, mod 2^32); state goes to DONE.
REQ-015 dig_valid SHALL rise exactly 64 clk edges after the accept edge.
REQ-016 In DONE: dig_valid=1 and digest is held stable until dig_ready; dig_valid&dig_ready returns to IDLE.
REQ-017 blk_ready SHALL be 0 outside IDLE; blk_valid outside IDLE is ignored and does not change state.
REQ-018 cnt SHALL be 6 bits and SHALL NOT wrap within a block; the transition to DONE happens at cnt=63.
REQ-019 digest SHALL continuously show the chaining value; it is defined only while dig_valid=1.

Reset
REQ-020 rst_n low SHALL force, at any time including mid-RUN, the following; the in-flight block is discarded.
- state=IDLE, cnt=0.
- chaining value = IV {D,C,B,A} = {10325476,98badcfe,efcdab89,67452301} hex.
- blk_ready=1, dig_valid=0, busy=0.
REQ-021 The first edge after rst_n releases SHALL be able to accept a block.

Configuration
REQ-022 With macro MD5_MULTIBLOCK_CHAIN_EN defined, blk_first=0 SHALL start from the previous chaining value, allowing multi-block messages.
REQ-023 Without MD5_MULTIBLOCK_CHAIN_EN, every block SHALL start from the IV; blk_first SHALL be ignored.

Structure
REQ-024 Package md5_pkg SHALL hold the following.
- IV constants.
- state enum.
- K table (64x32) and S table (64x5) as constant functions.
- g-index function.
REQ-025 Sub-module md5_step SHALL be a combinational single step: inputs A..D, M, K, S, round; output new B.

Verification
REQ-026 Empty message: word0=00000080, other words 0, blk_first=1 -> dig_valid at accept+64, digest {D,C,B,A} = {7e42f8ec,980980e9,04b2008f,d98c1dd4}.
REQ-027 "abc": word0=80636261, word14=00000018, others 0, blk_first=1 -> digest {727fe128,7d3f96d6,b04fd23c,98500190}.
REQ-028 Backpressure: hold dig_ready=0 for 10 cycles in DONE -> digest stable, blk_ready=0, and a blk_valid pulse is ignored; dig_ready=1 -> IDLE next edge.
REQ-029 Reset at cnt=30 -> next cycle IDLE with chaining value = IV; a fresh "abc" then gives the REQ-027 digest.
REQ-030 With MD5_MULTIBLOCK_CHAIN_EN: the 2-block 64-byte "a"x64 message -> MD5 = 014842d480b571495a4a0363793f7367; without the macro, block 2 gives the IV-based single-block result.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants, FSM state type and per-step table lookups.
// MD5_MULTIBLOCK_CHAIN_EN (used by md5_iter_ctrl) enables block chaining.
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [127:0] IV = {IV_D, IV_C, IV_B, IV_A};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } md5_state_e;

  function automatic logic [31:0] md5_k(input logic [5:0] idx);
    case (idx)
      6'd0:  return 32'hd76aa478;
      6'd1:  return 32'he8c7b756;
      6'd2:  return 32'h242070db;
      6'd3:  return 32'hc1bdceee;
      6'd4:  return 32'hf57c0faf;
      6'd5:  return 32'h4787c62a;
      6'd6:  return 32'ha8304613;
      6'd7:  return 32'hfd469501;
      6'd8:  return 32'h698098d8;
      6'd9:  return 32'h8b44f7af;
      6'd10: return 32'hffff5bb1;
      6'd11: return 32'h895cd7be;
      6'd12: return 32'h6b901122;
      6'd13: return 32'hfd987193;
      6'd14: return 32'ha679438e;
      6'd15: return 32'h49b40821;
      6'd16: return 32'hf61e2562;
      6'd17: return 32'hc040b340;
      6'd18: return 32'h265e5a51;
      6'd19: return 32'he9b6c7aa;
      6'd20: return 32'hd62f105d;
      6'd21: return 32'h02441453;
      6'd22: return 32'hd8a1e681;
      6'd23: return 32'he7d3fbc8;
      6'd24: return 32'h21e1cde6;
      6'd25: return 32'hc33707d6;
      6'd26: return 32'hf4d50d87;
      6'd27: return 32'h455a14ed;
      6'd28: return 32'ha9e3e905;
      6'd29: return 32'hfcefa3f8;
      6'd30: return 32'h676f02d9;
      6'd31: return 32'h8d2a4c8a;
      6'd32: return 32'hfffa3942;
      6'd33: return 32'h8771f681;
      6'd34: return 32'h6d9d6122;
      6'd35: return 32'hfde5380c;
      6'd36: return 32'ha4beea44;
      6'd37: return 32'h4bdecfa9;
      6'd38: return 32'hf6bb4b60;
      6'd39: return 32'hbebfbc70;
      6'd40: return 32'h289b7ec6;
      6'd41: return 32'heaa127fa;
      6'd42: return 32'hd4ef3085;
      6'd43: return 32'h04881d05;
      6'd44: return 32'hd9d4d039;
      6'd45: return 32'he6db99e5;
      6'd46: return 32'h1fa27cf8;
      6'd47: return 32'hc4ac5665;
      6'd48: return 32'hf4292244;
      6'd49: return 32'h432aff97;
      6'd50: return 32'hab9423a7;
      6'd51: return 32'hfc93a039;
      6'd52: return 32'h655b59c3;
      6'd53: return 32'h8f0ccc92;
      6'd54: return 32'hffeff47d;
      6'd55: return 32'h85845dd1;
      6'd56: return 32'h6fa87e4f;
      6'd57: return 32'hfe2ce6e0;
      6'd58: return 32'ha3014314;
      6'd59: return 32'h4e0811a1;
      6'd60: return 32'hf7537e82;
      6'd61: return 32'hbd3af235;
      6'd62: return 32'h2ad7d2bb;
      default: return 32'heb86d391;
    endcase
  endfunction

  // Shift amount depends only on the round and the step position within a group of four.
  function automatic logic [4:0] md5_s(input logic [5:0] idx);
    case ({idx[5:4], idx[1:0]})
      4'h0: return 5'd7;
      4'h1: return 5'd12;
      4'h2: return 5'd17;
      4'h3: return 5'd22;
      4'h4: return 5'd5;
      4'h5: return 5'd9;
      4'h6: return 5'd14;
      4'h7: return 5'd20;
      4'h8: return 5'd4;
      4'h9: return 5'd11;
      4'ha: return 5'd16;
      4'hb: return 5'd23;
      4'hc: return 5'd6;
      4'hd: return 5'd10;
      4'he: return 5'd15;
      default: return 5'd21;
    endcase
  endfunction

  function automatic logic [3:0] md5_g(input logic [5:0] idx);
    logic [3:0] i;
    i = idx[3:0];
    case (idx[5:4])
      2'd0:    return i;
      2'd1:    return 4'(i * 4'd5 + 4'd1);
      2'd2:    return 4'(i * 4'd3 + 4'd5);
      default: return 4'(i * 4'd7);
    endcase
  endfunction

endpackage

// File: rtl/md5_step.sv
// Combinational MD5 step: round function, add chain and left rotate; yields new B.
module md5_step (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  input  logic [1:0]  round,
  output logic [31:0] new_b
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;

  always_comb begin
    f = '0;
    case (round)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (b & d) | (c & ~d);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    sum = a + f + k + m;
    rot = (sum << s) | (sum >> (6'd32 - 6'(s)));
    new_b = b + rot;
  end

endmodule

// File: rtl/md5_iter_ctrl.sv
// Iterative MD5 block engine: one step per clock, 64 steps per 512-bit block.
// Define MD5_MULTIBLOCK_CHAIN_EN to let blk_first=0 continue from the previous chaining value.
module md5_iter_ctrl
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [127:0] digest,
  output logic         busy
);

  md5_state_e   state, state_nx;
  logic [5:0]   cnt;
  logic [511:0] blk_q;
  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  ca, cb, cc, cd;
  logic [3:0]   g_idx;
  logic [31:0]  m_word, k_word, step_b;
  logic [4:0]   s_amt;
  logic         accept, from_iv;

  assign accept = blk_valid && (state == ST_IDLE);

`ifdef MD5_MULTIBLOCK_CHAIN_EN
  assign from_iv = blk_first;
`else
  logic unused_blk_first;
  assign unused_blk_first = blk_first;
  assign from_iv = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    blk_ready = 1'b0;
    dig_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == 6'd63) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        dig_valid = 1'b1;
        if (dig_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign g_idx  = md5_g(cnt);
  assign m_word = blk_q[{g_idx, 5'd0} +: 32];
  assign k_word = md5_k(cnt);
  assign s_amt  = md5_s(cnt);

  md5_step u_step (
    .a     (wa),
    .b     (wb),
    .c     (wc),
    .d     (wd),
    .m     (m_word),
    .k     (k_word),
    .s     (s_amt),
    .round (cnt[5:4]),
    .new_b (step_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      blk_q <= '0;
      {wd, wc, wb, wa} <= '0;
      {cd, cc, cb, ca} <= IV;
    end else if (accept) begin
      cnt   <= '0;
      blk_q <= blk_data;
      if (from_iv) begin
        // Chaining value is reset too, so the final add is relative to the IV.
        {wd, wc, wb, wa} <= IV;
        {cd, cc, cb, ca} <= IV;
      end else begin
        {wd, wc, wb, wa} <= {cd, cc, cb, ca};
      end
    end else if (state == ST_RUN) begin
      wa <= wd;
      wb <= step_b;
      wc <= wb;
      wd <= wc;
      // Last step folds the freshly computed working words straight into the chain.
      if (cnt == 6'd63) begin
        ca <= ca + wd;
        cb <= cb + step_b;
        cc <= cc + wb;
        cd <= cd + wc;
      end else begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  assign digest = {cd, cc, cb, ca};

endmodule

// File: tb/tb_md5_iter_ctrl.sv
// Self-checking bench for md5_iter_ctrl against a loop-based MD5 compression model.
// Honours MD5_MULTIBLOCK_CHAIN_EN the same way the design does.
module tb_md5_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b0;
  logic [127:0] digest;
  logic         busy;

  int unsigned total = 0;
  int unsigned bad = 0;

`ifdef MD5_MULTIBLOCK_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  localparam logic [127:0] IV_REF = 128'h10325476_98badcfe_efcdab89_67452301;

  localparam int unsigned KT[64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int unsigned SHT[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic [127:0] ref_cv = 128'h10325476_98badcfe_efcdab89_67452301;

  md5_iter_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] md5_ref(input logic [127:0] cv, input logic [511:0] blk);
    int unsigned m[16];
    int unsigned a, b, c, d, f, t, sh, g, r;
    for (int i = 0; i < 16; i++) m[i] = blk[32*i +: 32];
    a = cv[31:0]; b = cv[63:32]; c = cv[95:64]; d = cv[127:96];
    for (int i = 0; i < 64; i++) begin
      r = i / 16;
      if (r == 0)      begin f = (b & c) | (~b & d); g = i; end
      else if (r == 1) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (r == 2) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      t  = a + f + KT[i] + m[g];
      sh = SHT[r * 4 + i % 4];
      t  = (t << sh) | (t >> (32 - sh));
      a = d; d = c; c = b; b = b + t;
    end
    md5_ref = {cv[127:96] + d, cv[95:64] + c, cv[63:32] + b, cv[31:0] + a};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Called #1 after a clock edge with the DUT idle; returns #1 after dig_valid is seen.
  task automatic send_block(input logic [511:0] blk, input logic first, input string tag);
    int unsigned n;
    blk_data  = blk;
    blk_first = first;
    blk_valid = 1'b1;
    chk({tag, "_ready"}, 128'(blk_ready), 128'(1));
    @(posedge clk); #1;
    blk_valid = 1'b0;
    if (first || !CHAIN_EN) ref_cv = md5_ref(IV_REF, blk);
    else                    ref_cv = md5_ref(ref_cv, blk);
    n = 0;
    while (!dig_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 30) begin
        chk({tag, "_busy_run"}, 128'(busy), 128'(1));
        chk({tag, "_ready_run"}, 128'(blk_ready), 128'(0));
      end
    end
    chk({tag, "_latency"}, 128'(n), 128'(64));
    chk({tag, "_digest"}, digest, ref_cv);
  endtask

  task automatic consume(input int unsigned hold, input string tag);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 128'(dig_valid), 128'(1));
      chk({tag, "_hold_digest"}, digest, ref_cv);
    end
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    chk({tag, "_idle_ready"}, 128'(blk_ready), 128'(1));
    chk({tag, "_idle_valid"}, 128'(dig_valid), 128'(0));
    chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_empty, blk_abc, blk_a64, blk_pad, tmp;
    logic [127:0] exp2;

    blk_empty = '0;
    blk_empty[31:0] = 32'h00000080;
    blk_abc = '0;
    blk_abc[31:0] = 32'h80636261;
    blk_abc[14*32 +: 32] = 32'h00000018;
    for (int i = 0; i < 16; i++) blk_a64[32*i +: 32] = 32'h61616161;
    blk_pad = '0;
    blk_pad[31:0] = 32'h00000080;
    blk_pad[14*32 +: 32] = 32'h00000200;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(blk_ready), 128'(1));
    chk("rst_valid", 128'(dig_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_digest", digest, IV_REF);

    // Block offered on the very first edge after reset release
    rst_n = 1'b1;
    send_block(blk_empty, 1'b1, "empty");
    chk("empty_known", digest, 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4);
    consume(0, "empty");

    send_block(blk_abc, 1'b1, "abc");
    chk("abc_known", digest, 128'h727fe128_7d3f96d6_b04fd23c_98500190);

    // Backpressure with an ignored blk_valid pulse in DONE
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_digest", digest, 128'h727fe128_7d3f96d6_b04fd23c_98500190);
      chk("bp_ready", 128'(blk_ready), 128'(0));
      chk("bp_valid", 128'(dig_valid), 128'(1));
      if (i == 3) begin
        blk_data  = rand_block();
        blk_first = 1'b1;
        blk_valid = 1'b1;
      end else begin
        blk_valid = 1'b0;
      end
    end
    consume(0, "bp");

    // Reset in the middle of a block
    blk_data  = rand_block();
    blk_first = 1'b1;
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(blk_ready), 128'(1));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_valid", 128'(dig_valid), 128'(0));
    chk("mid_rst_digest", digest, IV_REF);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_cv = IV_REF;
    send_block(blk_abc, 1'b1, "abc2");
    chk("abc2_known", digest, 128'h727fe128_7d3f96d6_b04fd23c_98500190);
    consume(2, "abc2");

    // Two-block message: 64 x 'a' then the padding block
    send_block(blk_a64, 1'b1, "a64_b1");
    consume(1, "a64_b1");
`ifdef MD5_MULTIBLOCK_CHAIN_EN
    exp2 = 128'h67733f79_63034a5a_4971b580_d4424801;
`else
    exp2 = md5_ref(IV_REF, blk_pad);
`endif
    send_block(blk_pad, 1'b0, "a64_b2");
    chk("a64_known", digest, exp2);
    consume(0, "a64_b2");

    // Random blocks with random blk_first and random consumer delay
    for (int n = 0; n < 8; n++) begin
      tmp = rand_block();
      send_block(tmp, 1'($urandom_range(0, 1)), "rand");
      consume($urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
